led_pattern_drive: RTL and testbench
====================================

// Module: led_pattern_drive
// PURPOSE
//  Parametrised successor to the fixed LED flip driver. Drives P_LED_NUMBER LEDs with a
//  run-time selectable pattern (off / blink / running light / ping-pong). The pattern advances
//  once every P_LED_CNT enabled clocks. Sits after the board PLL; reset is fed from PLL locked.
// PARAMETERS
//  P_LED_NUMBER  4     number of LEDs, >=1
//  P_LED_CNT     5000  enabled clocks per pattern step, >=1
//  P_LED_ON      1     output level that lights an LED (1 = active-high, 0 = active-low)
//  P_PWM_W       4     duty/PWM counter width (used only with LED_PWM_EN)
// PORTS
//  i_clk       in   1             single clock, all logic rising-edge
//  i_rst_n     in   1             synchronous active-low reset
//  i_en        in   1             1 = run; 0 = freeze step counter, pattern and direction
//  i_mode      in   2             requested mode: 0 OFF, 1 BLINK, 2 RUN, 3 PINGPONG
//  i_duty      in   P_PWM_W       brightness duty (port present only with LED_PWM_EN)
//  o_led       out  P_LED_NUMBER  LED drive, registered
//  o_mode      out  2             mode currently in effect
//  o_step      out  1             1-cycle pulse, high the cycle the pattern updates
// BEHAVIOUR
//  Reset (i_rst_n=0 at a clock edge): step cnt=0, pattern=0, mode=OFF, dir=left, o_step=0,
//   o_led = all LEDs off ({N{~P_LED_ON}}). Reset mid-operation aborts the step with no partial update.
//  Step counter: 0..P_LED_CNT-1, increments only when i_en=1. tick = i_en && cnt==P_LED_CNT-1;
//   on tick cnt wraps to 0. P_LED_CNT=1 -> tick on every enabled clock.
//  Mode: i_mode is sampled only on tick; changes between ticks are ignored.
//   On tick with i_mode!=o_mode: o_mode<=i_mode, pattern<=init(i_mode), dir<=left.
//   init: OFF=0, BLINK=all ones, RUN=1 (bit0), PINGPONG=1 (bit0).
//   On tick with i_mode==o_mode, pattern advances:
//    OFF: stays 0. BLINK: pattern <= ~pattern.
//    RUN: rotate left by 1; bit N-1 wraps to bit0.
//    PINGPONG: dir left -> shift left; when the new pattern has bit N-1 set, dir<=right.
//     dir right -> shift right; when the new pattern has bit0 set, dir<=left. Endpoints are
//     lit for exactly one step (no repeat). Sequence for N=4: 1,2,4,8,4,2,1,2...
//  N=1: RUN/PINGPONG hold pattern=1; BLINK toggles; dir unused.
//  o_step: registered, high the same cycle o_led/o_mode show the new value (1 clk after tick).
//  o_led = P_LED_ON ? (pattern & gate) : ~(pattern & gate); gate = all ones without PWM.
//  Latency: pattern change visible on o_led one clock after the tick edge.
//  i_en=0 during a tick cycle: no tick, no step, counter holds; resumes where it stopped.
// CONFIGURATION
//  LED_PWM_EN defined: i_duty port exists; free-running P_PWM_W-bit pwm_cnt (reset 0, wraps,
//   runs regardless of i_en); gate = {N{pwm_cnt < i_duty}}. i_duty=0 -> LEDs always off;
//   i_duty=2^W-1 -> on (2^W-1)/2^W of cycles. o_mode/o_step unaffected.
//  LED_PWM_EN undefined: no i_duty port, no pwm counter; LEDs lit at full duty.
// TESTING (N=4, P_LED_CNT=4, P_LED_ON=1 unless stated)
//  1 Reset: hold i_rst_n=0 5 clks with i_mode=2 -> o_led=0000, o_mode=0, o_step=0 throughout.
//  2 RUN: release reset, i_en=1, i_mode=2 -> first tick at clk 4 sets o_mode=2, o_led=0001;
//    then every 4 clks 0010,0100,1000,0001; o_step pulses once per step.
//  3 PINGPONG + mode change: i_mode=3 -> 0001,0010,0100,1000,0100,0010,0001; switch i_mode to 1
//    mid-step -> no effect until tick, then o_led=1111, next step 0000.
//  4 Freeze: in RUN drop i_en for 10 clks at cnt=2 -> o_led and o_step frozen; after i_en=1 the
//    next step occurs after exactly 2 more enabled clks.
//  5 Polarity/edge: P_LED_ON=0, P_LED_CNT=1, N=1, i_mode=1 -> o_led after reset=1,
//    then 0,1,0... toggling every clock.
//  6 LED_PWM_EN, P_PWM_W=4, BLINK all-on, i_duty=4 -> each LED high 4 of every 16 clks;
//    i_duty=0 -> o_led stays 0000 while o_step still pulses.

Source files
------------

// File: rtl/led_pattern_drive.sv
// led_pattern_drive: selectable LED pattern driver (off/blink/run/ping-pong) stepping every P_LED_CNT enabled clocks.
// Define LED_PWM_EN to add the i_duty port and a free-running PWM brightness gate.
module led_pattern_drive #(
  parameter int P_LED_NUMBER = 4,
  parameter int P_LED_CNT    = 5000,
  parameter int P_LED_ON     = 1,
  parameter int P_PWM_W      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [1:0]              i_mode,
`ifdef LED_PWM_EN
  input  logic [P_PWM_W-1:0]      i_duty,
`endif
  output logic [P_LED_NUMBER-1:0] o_led,
  output logic [1:0]              o_mode,
  output logic                    o_step
);
  localparam int N  = P_LED_NUMBER;
  localparam int CW = P_LED_CNT > 1 ? $clog2(P_LED_CNT) : 1;
  typedef enum logic [1:0] {OFF, BLINK, RUN, PING} mode_t;
  mode_t         mode, mode_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  pat, pat_nxt, adv, init, pp, gate, led_nxt;
  logic          dir, dir_nxt, tick, chg;
  assign o_mode = mode;
`ifdef LED_PWM_EN
  logic [P_PWM_W-1:0] pwm_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 1'b1;
  end
  assign gate = {N{pwm_cnt < i_duty}};
`else
  assign gate = '1;
`endif
  // dir: 0 = moving toward bit N-1, 1 = moving toward bit 0
  always_comb begin
    tick     = i_en && cnt == CW'(P_LED_CNT - 1);
    cnt_nxt  = !i_en ? cnt : tick ? '0 : cnt + 1'b1;
    pp       = N == 1 ? pat : dir ? pat >> 1 : pat << 1;
    adv      = mode == BLINK ? ~pat : mode == RUN ? (pat << 1) | (pat >> (N - 1)) : mode == PING ? pp : '0;
    init     = i_mode == 2'd0 ? '0 : i_mode == 2'd1 ? '1 : N'(1);
    chg      = mode != mode_t'(i_mode);
    pat_nxt  = !tick ? pat : chg ? init : adv;
    dir_nxt  = !tick ? dir : chg ? 1'b0 : mode != PING ? dir : dir ? !pp[0] : pp[N-1];
    mode_nxt = tick ? mode_t'(i_mode) : mode;
    led_nxt  = P_LED_ON != 0 ? pat_nxt & gate : ~(pat_nxt & gate);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      pat    <= '0;
      mode   <= OFF;
      dir    <= 1'b0;
      o_step <= 1'b0;
      o_led  <= {N{P_LED_ON == 0}};
    end else begin
      cnt    <= cnt_nxt;
      pat    <= pat_nxt;
      mode   <= mode_nxt;
      dir    <= dir_nxt;
      o_step <= tick;
      o_led  <= led_nxt;
    end
  end
endmodule

// File: tb/tb_led_pattern_drive.sv
// tb_led_pattern_drive: directed stimulus with a step-index pattern model checked every cycle.
module tb_led_pattern_drive;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [1:0] mode, mode2;
  logic [3:0] duty;
  logic [3:0] led1;
  logic [0:0] led2;
  logic [1:0] om1, om2;
  logic       st1, st2;
  int vecs = 0, errs = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;

  led_pattern_drive #(.P_LED_NUMBER(4), .P_LED_CNT(4), .P_LED_ON(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode),
`ifdef LED_PWM_EN
    .i_duty(duty),
`endif
    .o_led(led1), .o_mode(om1), .o_step(st1));

  led_pattern_drive #(.P_LED_NUMBER(1), .P_LED_CNT(1), .P_LED_ON(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode2),
`ifdef LED_PWM_EN
    .i_duty(duty),
`endif
    .o_led(led2), .o_mode(om2), .o_step(st2));

  int         m_cnt[2], m_phase[2];
  logic [1:0] m_mode[2];
  logic       m_step[2];
  logic       m_gate;

  // pattern as a function of mode and number of same-mode steps taken
  function automatic logic [3:0] pat_of(int n, logic [1:0] md, int ph);
    int per, k;
    logic [3:0] mask;
    mask = 4'((1 << n) - 1);
    per  = 2 * n - 2;
    k    = per > 0 ? ph % per : 0;
    k    = k < n ? k : per - k;
    case (md)
      2'd0:    return 4'd0;
      2'd1:    return ph % 2 == 0 ? mask : 4'd0;
      2'd2:    return 4'(1 << (ph % n));
      default: return 4'(1 << k);
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] <= 0; m_phase[k] <= 0; m_mode[k] <= 2'd0; m_step[k] <= 1'b0;
      end else begin
        m_step[k] <= 1'b0;
        if (en) begin
          if (m_cnt[k] == (k == 0 ? 3 : 0)) begin
            m_cnt[k]  <= 0;
            m_step[k] <= 1'b1;
            if ((k == 0 ? mode : mode2) != m_mode[k]) begin
              m_mode[k] <= k == 0 ? mode : mode2; m_phase[k] <= 0;
            end else m_phase[k] <= m_phase[k] + 1;
          end else m_cnt[k] <= m_cnt[k] + 1;
        end
      end
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] m_pwm;
  always @(posedge clk) begin
    if (!rst_n) begin m_pwm <= 4'd0; m_gate <= 1'b0; end
    else begin m_pwm <= m_pwm + 4'd1; m_gate <= m_pwm < duty; end
  end
`else
  assign m_gate = 1'b1;
`endif

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("model_led1", led1, pat_of(4, m_mode[0], m_phase[0]) & {4{m_gate}});
    chk("model_mode1", {2'b0, om1}, {2'b0, m_mode[0]});
    chk("model_step1", {3'b0, st1}, {3'b0, m_step[0]});
    chk("model_led2", {3'b0, led2}, ~(pat_of(1, m_mode[1], m_phase[1]) & {4{m_gate}}) & 4'b0001);
    chk("model_mode2", {2'b0, om2}, {2'b0, m_mode[1]});
    chk("model_step2", {3'b0, st2}, {3'b0, m_step[1]});
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic lit(string nm, logic [3:0] pat, logic stp);
    chk({nm, "_led"}, led1, pat & {4{m_gate}});
    chk({nm, "_step"}, {3'b0, st1}, {3'b0, stp});
  endtask

  logic [3:0] run_seq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] pp_seq[7]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd2; mode2 = 2'd1; duty = 4'hf;
    step();
    chk_on = 1'b1;
    repeat (4) begin
      step();
      chk("rst_led1", led1, 4'b0000);
      chk("rst_mode1", {2'b0, om1}, 4'd0);
      chk("rst_led2", {3'b0, led2}, 4'b0001);
    end
    rst_n = 1'b1; en = 1'b1;
    step();
    chk("edge_led2_first", {3'b0, led2}, 4'd0);
    step();
    chk("edge_led2_second", {3'b0, led2}, 4'd1);
    step(2);
    lit("run_first", 4'b0001, 1'b1);
    chk("run_first_mode", {2'b0, om1}, 4'd2);
    foreach (run_seq[i]) begin
      step(3);
      lit("run_mid", run_seq[i == 0 ? 3 : i - 1], 1'b0);
      step();
      lit("run_seq", run_seq[i], 1'b1);
    end
    step(2);
    en = 1'b0;
    repeat (10) begin step(); lit("freeze", 4'b0001, 1'b0); end
    en = 1'b1;
    step();
    lit("resume_1", 4'b0001, 1'b0);
    step();
    lit("resume_2", 4'b0010, 1'b1);
    mode = 2'd3;
    foreach (pp_seq[i]) begin step(4); lit("pingpong", pp_seq[i], 1'b1); end
    step(2);
    mode = 2'd1;
    step();
    lit("mode_ignored", 4'b0001, 1'b0);
    step();
    lit("blink_on", 4'b1111, 1'b1);
    chk("blink_mode", {2'b0, om1}, 4'd1);
    step(4);
    lit("blink_off", 4'b0000, 1'b1);
    step(4);
`ifdef LED_PWM_EN
    duty = 4'd4;
    step(32);
    duty = 4'd0;
    step(2);
    repeat (16) begin step(); chk("duty0_led", led1, 4'b0000); end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
